// File: rtl/axis_frame_len_check_pkg.sv
// Shared types for the AXI-Stream frame length qualifier.
// Latency: n/a (types only).
// Backpressure: n/a.
package axis_frame_len_check_pkg;

  // Checker FSM: between frames, mid-frame, draining a truncated remainder
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // Per-beat length compare result
  typedef struct packed {
    logic is_short;  // last beat arrived before the minimum length
    logic is_long;   // non-last beat hit the maximum length, frame is cut here
  } len_cmp_t;

endpackage

// File: rtl/axis_frame_len_check_pipe.sv
// One-entry registered AXI-Stream stage carrying a packed payload.
// Latency: 1 cycle from accepted input to output.
// Backpressure: ready = downstream ready | empty; holds output stable while stalled.
module axis_pipe_reg #(
  parameter int WIDTH = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_s_dat,
  input  logic             i_s_vld,
  output logic             o_s_rdy,
  output logic [WIDTH-1:0] o_m_dat,
  output logic             o_m_vld,
  input  logic             i_m_rdy
);

  logic [WIDTH-1:0] r_dat;
  logic             r_vld;

  assign o_s_rdy = i_m_rdy | ~r_vld;
  assign o_m_dat = r_dat;
  assign o_m_vld = r_vld;

  // Load a new beat whenever the register is empty or being drained this cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (o_s_rdy) begin
      r_vld <= i_s_vld;
      if (i_s_vld) begin
        r_dat <= i_s_dat;
      end
    end
  end

endmodule

// File: rtl/axis_frame_len_check.sv
// Qualifies AXI-Stream frames by beat count; flags bad frames via tuser on tlast, truncates oversize ones.
// Latency: 1 cycle (single registered output stage), status pulses aligned with the loaded last beat.
// Backpressure: input ready follows the output register, except while draining a truncated frame (always ready).
module axis_frame_len_check
  import axis_frame_len_check_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LEN_WIDTH-1:0]  length_min,
  input  logic [LEN_WIDTH-1:0]  length_max,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  output_axis_tuser,
  output logic                  frame_good,
  output logic                  frame_bad,
  output logic                  err_short,
  output logic                  err_long
);

  localparam int PW = DATA_WIDTH + 2;
  localparam logic [LEN_WIDTH-1:0] ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  state_t               r_state;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic [LEN_WIDTH-1:0] r_min;
  logic [LEN_WIDTH-1:0] r_max;
  logic                 r_sticky;
  logic                 r_good;
  logic                 r_bad;
  logic                 r_short;
  logic                 r_long;

  logic                 w_idle;
  logic                 w_drop;
  logic                 w_fire;
  logic [LEN_WIDTH-1:0] w_cnt_next;
  logic [LEN_WIDTH-1:0] w_min;
  logic [LEN_WIDTH-1:0] w_max;
  logic                 w_sticky_next;
  len_cmp_t             w_cmp;
  logic                 w_bad;
  logic                 w_out_last;
  logic                 w_out_user;
  logic                 w_pipe_s_vld;
  logic                 w_pipe_s_rdy;
  logic [PW-1:0]        w_pipe_s_dat;
  logic [PW-1:0]        w_pipe_m_dat;

  assign w_idle = (r_state == ST_IDLE);
  assign w_drop = (r_state == ST_DROP);

  // While draining, swallow every input beat without touching the output register
  assign input_axis_tready = w_drop | w_pipe_s_rdy;
  assign w_pipe_s_vld      = input_axis_tvalid & ~w_drop;
  assign w_fire            = input_axis_tvalid & input_axis_tready;

  // The first beat of a frame uses the live limits; later beats use the shadows
  assign w_min         = w_idle ? length_min : r_min;
  assign w_max         = w_idle ? length_max : r_max;
  assign w_cnt_next    = w_idle ? ONE : ((&r_cnt) ? r_cnt : r_cnt + ONE);
  assign w_sticky_next = w_idle ? input_axis_tuser : (r_sticky | input_axis_tuser);

  // A beat carrying tlast is always a normal end of frame, even when it lands exactly on max
  always_comb begin
    w_cmp          = '0;
    w_cmp.is_short = input_axis_tlast & (w_cnt_next < w_min);
    w_cmp.is_long  = ~input_axis_tlast & (w_max != '0) & (w_cnt_next == w_max);
  end

  assign w_bad        = w_sticky_next | w_cmp.is_short;
  assign w_out_last   = input_axis_tlast | w_cmp.is_long;
  assign w_out_user   = input_axis_tlast ? w_bad : w_cmp.is_long;
  assign w_pipe_s_dat = {input_axis_tdata, w_out_last, w_out_user};

  axis_pipe_reg #(
    .WIDTH (PW)
  ) u_pipe (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_s_dat (w_pipe_s_dat),
    .i_s_vld (w_pipe_s_vld),
    .o_s_rdy (w_pipe_s_rdy),
    .o_m_dat (w_pipe_m_dat),
    .o_m_vld (output_axis_tvalid),
    .i_m_rdy (output_axis_tready)
  );

  assign output_axis_tdata = w_pipe_m_dat[PW-1:2];
  assign output_axis_tlast = w_pipe_m_dat[1];
  assign output_axis_tuser = w_pipe_m_dat[0];

  assign frame_good = r_good;
  assign frame_bad  = r_bad;
  assign err_short  = r_short;
  assign err_long   = r_long;

  // Frame FSM: track count/limits/error, pulse status as the closing beat loads into the output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_min    <= '0;
      r_max    <= '0;
      r_sticky <= 1'b0;
      r_good   <= 1'b0;
      r_bad    <= 1'b0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
    end else begin
      r_good  <= 1'b0;
      r_bad   <= 1'b0;
      r_short <= 1'b0;
      r_long  <= 1'b0;
      if (w_fire) begin
        unique case (r_state)
          ST_IDLE, ST_PASS: begin
            if (w_idle) begin
              r_min <= length_min;
              r_max <= length_max;
            end
            r_cnt    <= w_cnt_next;
            r_sticky <= w_sticky_next;
            if (input_axis_tlast) begin
              r_state <= ST_IDLE;
              r_good  <= ~w_bad;
              r_bad   <= w_bad;
              r_short <= w_cmp.is_short;
            end else if (w_cmp.is_long) begin
              r_state <= ST_DROP;
              r_bad   <= 1'b1;
              r_long  <= 1'b1;
            end else begin
              r_state <= ST_PASS;
            end
          end
          ST_DROP: begin
            if (input_axis_tlast) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_len_check.sv
// Self-checking bench for axis_frame_len_check: directed frames plus randomized traffic and backpressure.
// Expected output beats and status pulses come from a frame-level model built on queues.
// Output stage is monitored continuously for loss, duplication and stability while stalled.
module tb_axis_frame_len_check;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] length_min = '0;
  logic [15:0] length_max = '0;
  logic [7:0]  input_axis_tdata = '0;
  logic        input_axis_tvalid = 1'b0;
  logic        input_axis_tready;
  logic        input_axis_tlast = 1'b0;
  logic        input_axis_tuser = 1'b0;
  logic [7:0]  output_axis_tdata;
  logic        output_axis_tvalid;
  logic        output_axis_tready = 1'b1;
  logic        output_axis_tlast;
  logic        output_axis_tuser;
  logic        frame_good, frame_bad, err_short, err_long;

  axis_frame_len_check #(.DATA_WIDTH(8), .LEN_WIDTH(16)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .length_min         (length_min),
    .length_max         (length_max),
    .input_axis_tdata   (input_axis_tdata),
    .input_axis_tvalid  (input_axis_tvalid),
    .input_axis_tready  (input_axis_tready),
    .input_axis_tlast   (input_axis_tlast),
    .input_axis_tuser   (input_axis_tuser),
    .output_axis_tdata  (output_axis_tdata),
    .output_axis_tvalid (output_axis_tvalid),
    .output_axis_tready (output_axis_tready),
    .output_axis_tlast  (output_axis_tlast),
    .output_axis_tuser  (output_axis_tuser),
    .frame_good         (frame_good),
    .frame_bad          (frame_bad),
    .err_short          (err_short),
    .err_long           (err_long)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] dat; logic last; logic user; } beat_t;
  typedef struct packed { logic good; logic bad; logic shrt; logic lng; } pulse_t;

  int     vec_cnt = 0;
  int     err_cnt = 0;
  int     cyc = 0;
  beat_t  obs_q[$];
  int     obs_cyc[$];
  pulse_t pls_q[$];
  int     acc_cyc[$];
  beat_t  exp_q[$];
  pulse_t exp_p;
  logic [7:0] fr_dat[$];
  logic       fr_usr[$];
  logic   rnd_rdy = 1'b0;
  logic   lat_chk = 1'b0;
  beat_t  held;
  logic   stalled = 1'b0;

  always @(posedge clk) cyc++;

  // Output-side driver: random or fixed ready, changed just after each edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      output_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: capture transferred beats and status pulses, check hold-while-stalled
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        vec_cnt++;
        assert ({output_axis_tvalid, output_axis_tdata, output_axis_tlast, output_axis_tuser} === {1'b1, held})
        else begin
          err_cnt++;
          $error("FAIL stall_hold got=%h want=%h", {output_axis_tvalid, output_axis_tdata,
                 output_axis_tlast, output_axis_tuser}, {1'b1, held});
        end
      end
      if (output_axis_tvalid && output_axis_tready) begin
        obs_q.push_back({output_axis_tdata, output_axis_tlast, output_axis_tuser});
        obs_cyc.push_back(cyc);
      end
      stalled = output_axis_tvalid && !output_axis_tready;
      held = {output_axis_tdata, output_axis_tlast, output_axis_tuser};
      if (frame_good || frame_bad || err_short || err_long)
        pls_q.push_back({frame_good, frame_bad, err_short, err_long});
    end
  end

  // Frame-level reference: cut at max if longer, otherwise whole frame with bad = any tuser or too short
  function automatic void build_exp(input int mn, input int mx);
    int   n;
    logic anyu;
    logic shrt;
    logic bad;
    n = fr_dat.size();
    anyu = 1'b0;
    exp_q.delete();
    if (mx != 0 && n > mx) begin
      for (int i = 0; i < mx; i++)
        exp_q.push_back({fr_dat[i], (i == mx - 1), (i == mx - 1)});
      exp_p = 4'b0101;
    end else begin
      for (int i = 0; i < n; i++) anyu |= fr_usr[i];
      shrt = (n < mn);
      bad  = anyu | shrt;
      for (int i = 0; i < n; i++)
        exp_q.push_back({fr_dat[i], (i == n - 1), (i == n - 1) & bad});
      exp_p = {~bad, bad, shrt, 1'b0};
    end
  endfunction

  task automatic send_beat(input logic [7:0] d, input logic l, input logic u);
    int   t;
    logic acc;
    t = 0;
    acc = 1'b0;
    input_axis_tdata  = d;
    input_axis_tlast  = l;
    input_axis_tuser  = u;
    input_axis_tvalid = 1'b1;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = input_axis_tready;
      if (acc) acc_cyc.push_back(cyc);
      @(posedge clk);
      #1;
      t++;
    end
    input_axis_tvalid = 1'b0;
    if (!acc) begin
      vec_cnt++;
      err_cnt++;
      $error("FAIL accept_timeout got=not_ready want=ready");
    end
  endtask

  task automatic clear_q();
    obs_q.delete();
    obs_cyc.delete();
    pls_q.delete();
    acc_cyc.delete();
  endtask

  task automatic check_frame(input string tag);
    int    t;
    beat_t got;
    t = 0;
    while ((obs_q.size() < exp_q.size() || pls_q.size() < 1) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    vec_cnt++;
    assert (obs_q.size() === exp_q.size())
    else begin
      err_cnt++;
      $error("FAIL %s beat_count got=%0d want=%0d", tag, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      vec_cnt++;
      assert (got === exp_q[i])
      else begin
        err_cnt++;
        $error("FAIL %s beat%0d got=%h want=%h", tag, i, got, exp_q[i]);
      end
      if (lat_chk && i < obs_cyc.size() && i < acc_cyc.size()) begin
        vec_cnt++;
        assert (obs_cyc[i] === acc_cyc[i] + 1)
        else begin
          err_cnt++;
          $error("FAIL %s latency%0d got=%0d want=%0d", tag, i, obs_cyc[i], acc_cyc[i] + 1);
        end
      end
    end
    vec_cnt++;
    assert (pls_q.size() === 1 && pls_q[0] === exp_p)
    else begin
      err_cnt++;
      $error("FAIL %s pulses got_n=%0d got=%b want=%b", tag, pls_q.size(),
             (pls_q.size() > 0) ? pls_q[0] : 4'bx, exp_p);
    end
    clear_q();
  endtask

  task automatic run_frame(input int mn, input int mx, input string tag);
    length_min = 16'(mn);
    length_max = 16'(mx);
    build_exp(mn, mx);
    for (int i = 0; i < fr_dat.size(); i++)
      send_beat(fr_dat[i], (i == fr_dat.size() - 1), fr_usr[i]);
    check_frame(tag);
  endtask

  task automatic make_frame(input int n, input logic [7:0] base, input int usr_idx);
    fr_dat.delete();
    fr_usr.delete();
    for (int i = 0; i < n; i++) begin
      fr_dat.push_back(base + 8'(i));
      fr_usr.push_back(i == usr_idx);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    vec_cnt++;
    assert ({output_axis_tvalid, output_axis_tdata, output_axis_tlast, output_axis_tuser,
             frame_good, frame_bad, err_short, err_long, input_axis_tready} === 17'h00001)
    else begin
      err_cnt++;
      $error("FAIL %s got=%h want=%h", tag, {output_axis_tvalid, output_axis_tdata,
             output_axis_tlast, output_axis_tuser, frame_good, frame_bad, err_short,
             err_long, input_axis_tready}, 17'h00001);
    end
  endtask

  // Hard stop in case something wedges outside the bounded waits
  initial begin
    #900000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int mn;
    int mx;
    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Good 6-beat frame, full throughput, latency 1
    lat_chk = 1'b1;
    make_frame(6, 8'h10, -1);
    run_frame(4, 8, "good6");
    lat_chk = 1'b0;

    // Short 2-beat frame
    make_frame(2, 8'h20, -1);
    run_frame(4, 8, "short2");

    // 12-beat frame truncated at 8, remainder drained, next frame normal
    make_frame(12, 8'h30, -1);
    run_frame(4, 8, "long12");
    make_frame(5, 8'h50, -1);
    run_frame(4, 8, "after_trunc");

    // Exactly max beats with tlast on the last: normal end, not truncation
    make_frame(8, 8'h60, -1);
    run_frame(4, 8, "exact_max");

    // Upstream error on beat 2 only
    make_frame(5, 8'h70, 1);
    run_frame(4, 8, "tuser_b2");

    // Single-beat frames against min=1 and min=2
    make_frame(1, 8'h80, -1);
    run_frame(1, 0, "single_ok");
    make_frame(1, 8'h81, -1);
    run_frame(2, 0, "single_short");

    // 100 random frames, unlimited max, random backpressure
    rnd_rdy = 1'b1;
    for (int f = 0; f < 100; f++) begin
      n = $urandom_range(1, 10);
      fr_dat.delete();
      fr_usr.delete();
      for (int i = 0; i < n; i++) begin
        fr_dat.push_back(8'($urandom));
        fr_usr.push_back(1'b0);
      end
      run_frame(1, 0, "rand_good");
    end

    // Random limits (including min > max and min of 0) with occasional upstream errors
    for (int f = 0; f < 40; f++) begin
      n  = $urandom_range(1, 12);
      mn = $urandom_range(0, 6);
      mx = $urandom_range(0, 8);
      fr_dat.delete();
      fr_usr.delete();
      for (int i = 0; i < n; i++) begin
        fr_dat.push_back(8'($urandom));
        fr_usr.push_back($urandom_range(0, 9) == 0);
      end
      run_frame(mn, mx, "rand_lim");
    end
    rnd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset asserted during beat 3, then a clean 4-beat frame
    length_min = 16'd4;
    length_max = 16'd8;
    send_beat(8'h90, 1'b0, 1'b0);
    send_beat(8'h91, 1'b0, 1'b0);
    input_axis_tdata  = 8'h92;
    input_axis_tvalid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    input_axis_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("mid_reset_hold");
    rst_n = 1'b1;
    clear_q();
    @(posedge clk);
    #1;
    make_frame(4, 8'hA0, -1);
    run_frame(4, 8, "post_reset4");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
